regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-bank write port (w_en/r_write/w_data) among
//  N_REQ writeback sources (ALU, load unit, multi-cycle mul/div). Each source
//  has a one-entry holding slot. One slot is granted per cycle into a
//  registered write stage. A per-register busy mask is exported for read-hazard stalls.
// PARAMETERS
//  N_REQ   3   number of writeback requesters (>=2)
//  XLEN    32  write data width
//  ADDR_W  5   register address width (32 registers)
// PORTS
//  clk        in   1             clock, all state on posedge
//  rst        in   1             asynchronous, active-high reset
//  req_valid  in   N_REQ         requester i presents a write
//  req_ready  out  N_REQ         slot i accepts this cycle
//  req_addr   in   N_REQ*ADDR_W  destination register, requester i at [i*ADDR_W +: ADDR_W]
//  req_data   in   N_REQ*XLEN    write data, requester i at [i*XLEN +: XLEN]
//  w_en       out  1             registered write enable to bank
//  r_write    out  ADDR_W        registered write address to bank
//  w_data     out  XLEN          registered write data to bank
//  grant_id   out  $clog2(N_REQ) index of source currently in write stage
//  busy       out  2**ADDR_W     bit r set while a write to r is pending
// BEHAVIOUR
//  - Reset: slots empty; w_en=0, r_write=0, w_data=0, grant_id=0, busy=0, RR pointer=0.
//    Assertion mid-operation discards all pending writes immediately.
//  - Transfer on req_valid[i] && req_ready[i].
//    req_ready[i] = !slot_valid[i] || grant[i] (refill in the same cycle a slot drains).
//  - addr==0: accepted (ready per rule) but not stored; never reaches bank, never sets busy.
//  - Arbitration each cycle over occupied slots only (an entry is granted at
//    earliest the cycle after acceptance): winner's addr/data are registered
//    into the write stage and its slot is cleared.
//    No occupied slot: w_en=0 next cycle; r_write/w_data hold their last values.
//  - Latency: accept at edge N -> w_en high during cycle N+1 -> bank written at edge N+2.
//  - Throughput: one write per cycle sustained; no bubble between grants.
//  - busy[r] = any valid slot with addr r OR (w_en && r_write==r); busy[0] always 0.
//  - Ordering: per-source FIFO order preserved; cross-source order = grant order.
//    Upstream must not issue a write to r from another source while busy[r] is set (bench asserts this).
//  - All N_REQ slots full and all requesters valid: each slot drains in turn;
//    no slot starves under round-robin.
// CONFIGURATION
//  RF_WB_ROUND_ROBIN_EN defined: round-robin.
//    The pointer moves to (granted index + 1) mod N_REQ after each grant.
//    Search starts at the pointer. The pointer holds when nothing is granted.
//  Undefined: fixed priority, lowest index wins; no pointer state.
//    Starvation of high indices is permitted.
// STRUCTURE
//  rf_pkg: XLEN, REG_ADDR_W, NUM_REGS constants; typedef struct packed
//    {logic [REG_ADDR_W-1:0] addr; logic [XLEN-1:0] data;} wb_req_t.
//  Sub-module wb_rr_arbiter: N-way one-hot grant from request vector + pointer.
//    Contains both arbitration modes selected by the macro.
//  Top level holds slots, write stage and busy-mask generation.
// TESTING
//  1 Reset: assert rst mid-stream with 3 slots full -> w_en=0, busy=0,
//    req_ready=3'b111 on release.
//  2 Single write: src0 addr=5 data=32'h1234_5678 at edge N -> w_en=1,
//    r_write=5, w_data=32'h1234_5678 in cycle N+1; busy[5]=1 through N+1, 0 after.
//  3 x0 drop: src1 addr=0 data=32'hFFFF_FFFF -> accepted, w_en stays 0, busy stays 0.
//  4 Contention, RR build: src0/1/2 write regs 7/8/9 same cycle and keep
//    re-requesting -> grant_id sequence 0,1,2,0,...; fixed build -> 0 every cycle, src1/2 stall.
//  5 Back-to-back: src2 streams 4 writes (regs 10..13) alone -> req_ready[2] stays 1,
//    w_en high 4 consecutive cycles, order 10,11,12,13.
//  6 Hazard: slot holds addr 20 while write stage holds addr 21 -> busy[20]=busy[21]=1, others 0.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and writeback request type for the register-file writeback arbiter
// Purpose: register-file geometry (XLEN, REG_ADDR_W, NUM_REGS) and the packed
//          writeback request record used by writeback sources.
// Ports:   none (package).
package rf_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - N-way one-hot grant from a request vector and a search pointer
// Purpose: picks one requester per cycle. With RF_WB_ROUND_ROBIN_EN defined the
//          search starts at ptr and wraps; otherwise the lowest index wins and
//          there is no pointer input.
// Ports:   req        in  N      requesting (occupied) slots
//          ptr        in  IDX_W  round-robin search start (RF_WB_ROUND_ROBIN_EN only)
//          grant      out N      one-hot winner
//          grant_idx  out IDX_W  binary index of the winner (0 when none)
//          grant_any  out 1      some request was granted
module wb_rr_arbiter
    import rf_pkg::*;
#(
    parameter  int N     = 3,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
`ifdef RF_WB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
`ifdef RF_WB_ROUND_ROBIN_EN
            // Wrap the search index without a modulo so N need not be a power of two.
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
`else
            j = k;
`endif
            if (!grant_any && req[j]) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-bank write port among N_REQ writeback sources
// Purpose: one holding slot per source; one occupied slot per cycle is moved into
//          a registered write stage. Exports a per-register busy mask for
//          read-hazard stalls. Writes to register 0 are accepted and dropped.
//          Arbitration: round-robin when RF_WB_ROUND_ROBIN_EN is defined,
//          fixed lowest-index priority otherwise.
// Ports:   clk, rst   clock; asynchronous active-high reset
//          req_valid  in  N_REQ         source i presents a write
//          req_ready  out N_REQ         slot i accepts this cycle
//          req_addr   in  N_REQ*ADDR_W  destination register of source i
//          req_data   in  N_REQ*XLEN    write data of source i
//          w_en       out 1             registered bank write enable
//          r_write    out ADDR_W        registered bank write address
//          w_data     out XLEN          registered bank write data
//          grant_id   out IDX_W         source currently in the write stage
//          busy       out 2**ADDR_W     register has a pending write
module regfile_wb_arbiter #(
    parameter  int N_REQ  = 3,
    parameter  int XLEN   = rf_pkg::XLEN,
    parameter  int ADDR_W = rf_pkg::REG_ADDR_W,
    localparam int IDX_W  = $clog2(N_REQ),
    localparam int NUM_R  = 1 << ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*XLEN-1:0]   req_data,
    output logic                    w_en,
    output logic [ADDR_W-1:0]       r_write,
    output logic [XLEN-1:0]         w_data,
    output logic [IDX_W-1:0]        grant_id,
    output logic [NUM_R-1:0]        busy
);

    logic [N_REQ-1:0]  slot_valid_q, slot_valid_d;
    logic [ADDR_W-1:0] slot_addr_q [N_REQ];
    logic [ADDR_W-1:0] slot_addr_d [N_REQ];
    logic [XLEN-1:0]   slot_data_q [N_REQ];
    logic [XLEN-1:0]   slot_data_d [N_REQ];

    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] r_write_q, r_write_d;
    logic [XLEN-1:0]   w_data_q, w_data_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;

    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_any;

`ifdef RF_WB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]  ptr_q, ptr_d;
`endif

    // Only occupied slots compete, so an entry is granted no earlier than the
    // cycle after it was accepted.
    wb_rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (slot_valid_q),
`ifdef RF_WB_ROUND_ROBIN_EN
        .ptr       (ptr_q),
`endif
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // A slot being drained this cycle can be refilled in the same cycle.
    assign req_ready = ~slot_valid_q | grant;

    always_comb begin
        slot_valid_d = slot_valid_q;
        for (int i = 0; i < N_REQ; i++) begin
            slot_addr_d[i] = slot_addr_q[i];
            slot_data_d[i] = slot_data_q[i];
        end
        w_en_d     = grant_any;
        r_write_d  = r_write_q;
        w_data_d   = w_data_q;
        grant_id_d = grant_id_q;

        if (grant_any) begin
            r_write_d  = slot_addr_q[grant_idx];
            w_data_d   = slot_data_q[grant_idx];
            grant_id_d = grant_idx;
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                slot_valid_d[i] = 1'b0;
            end
            // Writes to x0 complete the handshake but are never stored.
            if (req_valid[i] && req_ready[i] && (req_addr[i*ADDR_W +: ADDR_W] != '0)) begin
                slot_valid_d[i] = 1'b1;
                slot_addr_d[i]  = req_addr[i*ADDR_W +: ADDR_W];
                slot_data_d[i]  = req_data[i*XLEN +: XLEN];
            end
        end
    end

`ifdef RF_WB_ROUND_ROBIN_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
            end
            w_en_q     <= 1'b0;
            r_write_q  <= '0;
            w_data_q   <= '0;
            grant_id_q <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int i = 0; i < N_REQ; i++) begin
                slot_addr_q[i] <= slot_addr_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
            w_en_q     <= w_en_d;
            r_write_q  <= r_write_d;
            w_data_q   <= w_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign w_en     = w_en_q;
    assign r_write  = r_write_q;
    assign w_data   = w_data_q;
    assign grant_id = grant_id_q;

    // A register is busy while its write sits in a slot or in the write stage.
    always_comb begin
        busy = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (slot_valid_q[i]) begin
                busy[slot_addr_q[i]] = 1'b1;
            end
        end
        if (w_en_q) begin
            busy[r_write_q] = 1'b1;
        end
        busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

    localparam int N  = 3;
    localparam int AW = REG_ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*XLEN-1:0] req_data = '0;
    logic              w_en;
    logic [AW-1:0]     r_write;
    logic [XLEN-1:0]   w_data;
    logic [1:0]        grant_id;
    logic [NUM_REGS-1:0] busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N_REQ(N), .XLEN(XLEN), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .w_en      (w_en),
        .r_write   (r_write),
        .w_data    (w_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // Reference model: one optional pending entry per source, plus the bank write stage.
    bit          m_v [N];
    wb_req_t     m_slot [N];
    bit          m_wen;
    int          m_rw;
    logic [31:0] m_wd;
    int          m_gid;
    int          m_ptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0;
            m_slot[i] = '0;
        end
        m_wen = 0; m_rw = 0; m_wd = '0; m_gid = 0; m_ptr = 0;
    endtask

    // Which pending source writes next, or -1 when none is pending.
    function automatic int m_grant();
`ifdef RF_WB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++)
            if (m_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
        for (int k = 0; k < N; k++)
            if (m_v[k]) return k;
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int g = m_grant();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = !m_v[i] || (g == i);
        return r;
    endfunction

    function automatic logic [NUM_REGS-1:0] m_busy();
        logic [NUM_REGS-1:0] b = '0;
        for (int i = 0; i < N; i++) if (m_v[i]) b[m_slot[i].addr] = 1'b1;
        if (m_wen) b[m_rw] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic set_src(input int i, input bit v, input logic [AW-1:0] a, input logic [31:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_data[i*32 +: 32]  = d;
    endtask

    // Called at posedge+1: check ready, advance one clock, update model, check outputs.
    task automatic cycle();
        int g;
        logic [N-1:0] rdy;
        logic [AW-1:0] a;
        g   = m_grant();
        rdy = m_ready();
        chk("req_ready", req_ready, rdy);
        @(posedge clk);
        if (g >= 0) begin
            m_wen = 1; m_rw = m_slot[g].addr; m_wd = m_slot[g].data;
            m_gid = g; m_ptr = (g + 1) % N;
        end else begin
            m_wen = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (g == i) m_v[i] = 0;
            a = req_addr[i*AW +: AW];
            if (req_valid[i] && rdy[i] && a != 0) begin
                m_v[i] = 1;
                m_slot[i].addr = a;
                m_slot[i].data = req_data[i*32 +: 32];
            end
        end
        #1;
        chk("w_en", w_en, m_wen);
        chk("r_write", r_write, m_rw);
        chk("w_data", w_data, m_wd);
        chk("grant_id", grant_id, m_gid);
        chk("busy", busy, m_busy());
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) cycle();
    endtask

    initial begin
        logic [AW-1:0] ra;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w_en", w_en, 0);
        chk("rst_r_write", r_write, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 3'b111);
        rst = 1'b0;

        // Single write latency and busy window.
        set_src(0, 1, 5, 32'h1234_5678);
        cycle();
        chk("t2_busy5_accept", busy[5], 1);
        chk("t2_wen_accept", w_en, 0);
        set_src(0, 0, 0, 0);
        cycle();
        chk("t2_wen", w_en, 1);
        chk("t2_raddr", r_write, 5);
        chk("t2_wdata", w_data, 32'h1234_5678);
        chk("t2_busy5", busy[5], 1);
        cycle();
        chk("t2_wen_after", w_en, 0);
        chk("t2_busy_after", busy, 0);

        // Writes to x0 are accepted and dropped.
        set_src(1, 1, 0, 32'hFFFF_FFFF);
        chk("t3_ready1", req_ready[1], 1);
        cycle();
        chk("t3_wen", w_en, 0);
        chk("t3_busy", busy, 0);
        set_src(1, 0, 0, 0);
        cycle();
        chk("t3_wen2", w_en, 0);

        // Mid-stream reset with all slots full and a write in flight.
        for (int i = 0; i < N; i++) set_src(i, 1, AW'(i + 1), 32'hA000_0000 + i);
        cycle();
        cycle();
        #3 rst = 1'b1;
        #1;
        chk("t1_w_en", w_en, 0);
        chk("t1_busy", busy, 0);
        chk("t1_grant_id", grant_id, 0);
        req_valid = '0;
        m_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t1_ready", req_ready, 3'b111);

        // Contention: all sources keep re-requesting.
        for (int i = 0; i < N; i++) set_src(i, 1, AW'(7 + i), 32'hC000_0000 + i);
        cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
`ifdef RF_WB_ROUND_ROBIN_EN
            chk("t4_grant_seq", grant_id, k % N);
`else
            chk("t4_grant_fixed", grant_id, 0);
`endif
        end
        idle(5);

        // Back-to-back stream from source 2.
        for (int k = 0; k < 4; k++) begin
            set_src(2, 1, AW'(10 + k), 32'hB000_0000 + k);
            chk("t5_ready2", req_ready[2], 1);
            cycle();
            if (k >= 1) begin
                chk("t5_wen", w_en, 1);
                chk("t5_order", r_write, 10 + k - 1);
            end
        end
        set_src(2, 0, 0, 0);
        cycle();
        chk("t5_wen_last", w_en, 1);
        chk("t5_order_last", r_write, 13);
        cycle();
        chk("t5_wen_end", w_en, 0);

        // Hazard mask: slot holds 20 while the write stage holds 21.
        set_src(1, 1, 21, 32'h2121_2121);
        cycle();
        set_src(1, 0, 0, 0);
        set_src(0, 1, 20, 32'h2020_2020);
        cycle();
        chk("t6_busy", busy, 32'h0030_0000);
        idle(3);

        // Random traffic; each source owns registers congruent to its index mod N,
        // so no two sources ever target the same register.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                ra = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, 9) * N + i);
                set_src(i, bit'($urandom_range(0, 1)), ra, $urandom);
            end
            cycle();
        end
        idle(6);
        chk("end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
